spi_tx_scheduler: RTL and testbench

- Two-requester round-robin scheduler and sequencer for the 8-bit SPI byte shifter (EN/RST/DATA in; WAIT/SCLK/MOSI/CS out).
- Grants one requester at a time and latches its byte onto the shifter DATA bus.
- Releases the shifter from reset, waits for its WAIT-low completion, then acks the requester.
- Sits between the application logic (e.g. display and DAC command sources) and the single shared SPI output.

---
 rtl/spi_tx_scheduler_if.sv | 41 ++++
 rtl/spi_tx_scheduler.sv | 106 ++++++++++
 tb/tb_spi_tx_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_scheduler_if.sv
// spi_tx_scheduler_if
//   Bundles the requester handshakes and the SPI byte-shifter control lines
//   of the two-requester SPI transmit scheduler.
//   master : requester/shifter side (drives REQx, DATAx, SPI_WAIT)
//   slave  : scheduler side (drives ACKx, GNT, BUSY, ERR and the SPI_* controls)
//   Signals:
//     REQ0/REQ1    request, held until the matching ACK
//     DATA0/DATA1  request byte, stable while REQ is high
//     ACK0/ACK1    one-cycle completion pulse
//     GNT          one-hot grant {GNT1,GNT0}
//     BUSY         scheduler not idle
//     ERR          timeout indication, coincident with ACK
//     SPI_EN       shifter enable
//     SPI_RST      shifter reset (1 = idle, CS high)
//     SPI_DATA     byte presented to the shifter
//     SPI_WAIT     shifter busy/in-reset; 0 once the byte is done
interface spi_tx_scheduler_if;
  logic       REQ0;
  logic [7:0] DATA0;
  logic       ACK0;
  logic       REQ1;
  logic [7:0] DATA1;
  logic       ACK1;
  logic [1:0] GNT;
  logic       BUSY;
  logic       ERR;
  logic       SPI_EN;
  logic       SPI_RST;
  logic [7:0] SPI_DATA;
  logic       SPI_WAIT;

  modport master (
    output REQ0, DATA0, REQ1, DATA1, SPI_WAIT,
    input  ACK0, ACK1, GNT, BUSY, ERR, SPI_EN, SPI_RST, SPI_DATA
  );

  modport slave (
    input  REQ0, DATA0, REQ1, DATA1, SPI_WAIT,
    output ACK0, ACK1, GNT, BUSY, ERR, SPI_EN, SPI_RST, SPI_DATA
  );
endinterface

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//   Round-robin scheduler/sequencer placing bytes from two requesters onto a
//   single 8-bit SPI byte shifter. One requester is granted at a time; its byte
//   is latched onto SPI_DATA, the shifter is released from reset, completion
//   (SPI_WAIT low) or a timeout ends the transfer, the requester gets a
//   one-cycle ACK, and the shifter is held in reset for GAP_CYCLES before the
//   next arbitration.
//   Ports:
//     CLK  clock
//     RST  synchronous, active-high reset
//     bus  spi_tx_scheduler_if.slave (requester handshakes + shifter controls)
//   Parameters:
//     GAP_CYCLES  idle cycles with the shifter in reset between bytes (1..15)
//     TIMEOUT     RUN cycles before a transfer is aborted (20..255)
module spi_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 40
) (
  input  logic              CLK,
  input  logic              RST,
  spi_tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GCNT_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic       last;   // requester granted most recently (1 after reset so 0 wins first)
  logic [7:0] tcnt;
  logic [3:0] gcnt;
  logic       pick;   // requester that would be granted this cycle

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign pick = (bus.REQ0 & bus.REQ1) ? ~last : bus.REQ1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      last         <= 1'b1;
      tcnt         <= 8'd0;
      gcnt         <= 4'd0;
      bus.ACK0     <= 1'b0;
      bus.ACK1     <= 1'b0;
      bus.ERR      <= 1'b0;
      bus.GNT      <= 2'b00;
      bus.BUSY     <= 1'b0;
      bus.SPI_EN   <= 1'b1;
      bus.SPI_RST  <= 1'b1;
      bus.SPI_DATA <= 8'h00;
    end else begin
      // ACK/ERR are single-cycle pulses, only raised on entry to DONE.
      bus.ACK0   <= 1'b0;
      bus.ACK1   <= 1'b0;
      bus.ERR    <= 1'b0;
      bus.SPI_EN <= 1'b1;
      case (state)
        IDLE: begin
          bus.SPI_RST <= 1'b1;
          bus.GNT     <= 2'b00;
          if (bus.REQ0 | bus.REQ1) begin
            bus.SPI_DATA <= pick ? bus.DATA1 : bus.DATA0;
            bus.GNT      <= pick ? 2'b10 : 2'b01;
            last         <= pick;
            bus.SPI_RST  <= 1'b0;
            bus.BUSY     <= 1'b1;
            tcnt         <= 8'd0;
            state        <= RUN;
          end
        end
        RUN: begin
          tcnt <= tcnt + 8'd1;
          // The shifter sits in reset (WAIT=1) outside RUN, so a low WAIT here
          // always belongs to the current byte. Completion wins over timeout.
          if (!bus.SPI_WAIT) begin
            bus.ACK0 <= bus.GNT[0];
            bus.ACK1 <= bus.GNT[1];
            state    <= DONE;
          end else if (tcnt == TCNT_LAST) begin
            bus.ACK0 <= bus.GNT[0];
            bus.ACK1 <= bus.GNT[1];
            bus.ERR  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.SPI_RST <= 1'b1;
          bus.GNT     <= 2'b00;
          gcnt        <= 4'd0;
          state       <= GAP;
        end
        GAP: begin
          // Requests are deliberately not looked at until back in IDLE.
          gcnt <= gcnt + 4'd1;
          if (gcnt == GCNT_LAST) begin
            bus.BUSY <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
module tb_spi_tx_scheduler;
  localparam int GAP = 4;
  localparam int TO  = 40;
  localparam int NOM = 20;   // grant-to-ACK cycles with the nominal 19-cycle shifter

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_tx_scheduler_if bus();

  spi_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Behavioural byte shifter: counts cycles out of reset, shifts MSB first with
  // SCLK rising mid-bit, drops WAIT on its 19th enabled cycle.
  logic [4:0] c;
  logic       wait_force;
  logic       sclk, mosi;
  logic [4:0] bidx;
  always @(posedge clk) begin
    if (bus.SPI_RST) c <= 5'd0;
    else if (c != 5'd31) c <= c + 5'd1;
  end
  assign bidx         = 5'd7 - ((c - 5'd1) >> 1);
  assign sclk         = !bus.SPI_RST && (c >= 5'd2) && (c <= 5'd16) && !c[0];
  assign mosi         = (c >= 5'd1 && c <= 5'd16) ? bus.SPI_DATA[bidx[2:0]] : 1'b0;
  assign bus.SPI_WAIT = wait_force | bus.SPI_RST | (c < 5'd18);

  int n_cmp = 0, n_err = 0;

  // Reference model: transaction-level timeline counted from the grant.
  int       mt = 0;          // cycles since grant became visible (0 = idle)
  int       ack_at = NOM;
  bit       win = 0, last = 1, forced = 0;
  logic [7:0] exp_byte = 8'h00;
  logic [7:0] col = 8'h00;
  bit       psclk = 0;
  bit       drop_on_ack = 1, rnd = 0;
  int       ack0_cnt = 0, ack1_cnt = 0, err_cnt = 0;
  int       dly0 = 0, dly1 = 0;
  logic [7:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] eg;
    bit inx;
    // predict the next cycle from what the DUT samples at this posedge
    if (rst) begin
      mt = 0; last = 1;
    end else if (mt == 0) begin
      if (bus.REQ0 | bus.REQ1) begin
        win      = (bus.REQ0 && bus.REQ1) ? !last : bus.REQ1;
        last     = win;
        exp_byte = win ? bus.DATA1 : bus.DATA0;
        forced   = wait_force;
        ack_at   = forced ? TO + 1 : NOM;
        mt       = 1;
      end
    end else if (mt == ack_at + GAP) begin
      mt = 0;
    end else begin
      mt++;
    end
    @(negedge clk);
    inx = (mt >= 1 && mt <= ack_at);
    eg  = inx ? (win ? 2'b10 : 2'b01) : 2'b00;
    chk("gnt",     bus.GNT,     eg);
    chk("ack0",    bus.ACK0,    mt == ack_at && !win);
    chk("ack1",    bus.ACK1,    mt == ack_at && win);
    chk("err",     bus.ERR,     mt == ack_at && forced);
    chk("busy",    bus.BUSY,    mt != 0);
    chk("spi_rst", bus.SPI_RST, !inx);
    chk("spi_en",  bus.SPI_EN,  1'b1);
    if (inx) chk("spi_data", bus.SPI_DATA, exp_byte);
    if (mt == 1) begin col = 8'h00; obs_q.push_back(bus.SPI_DATA); end
    if (sclk && !psclk) col = {col[6:0], mosi};
    psclk = sclk;
    if (mt == ack_at && !forced) chk("mosi_byte", col, exp_byte);
    if (bus.ACK0) ack0_cnt++;
    if (bus.ACK1) ack1_cnt++;
    if (bus.ERR)  err_cnt++;
    if (drop_on_ack) begin
      if (bus.ACK0) begin bus.REQ0 = 1'b0; dly0 = $urandom_range(0, 8); end
      if (bus.ACK1) begin bus.REQ1 = 1'b0; dly1 = $urandom_range(0, 8); end
    end
    if (rnd) begin
      if (!bus.REQ0) begin
        if (dly0 == 0) begin bus.REQ0 = 1'b1; bus.DATA0 = 8'($urandom); end
        else begin dly0--; bus.DATA0 = 8'($urandom); end
      end
      if (!bus.REQ1) begin
        if (dly1 == 0) begin bus.REQ1 = 1'b1; bus.DATA1 = 8'($urandom); end
        else begin dly1--; bus.DATA1 = 8'($urandom); end
      end
    end
  endtask

  initial begin
    int a0, a1, e0;
    rst = 1'b1; wait_force = 1'b0;
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.DATA0 = 8'h00; bus.DATA1 = 8'h00;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_spi_data", bus.SPI_DATA, 8'h00);
    chk("rst_spi_rst",  bus.SPI_RST,  1'b1);
    chk("rst_gnt",      bus.GNT,      2'b00);
    rst = 1'b0;
    tick();

    // single byte
    a0 = ack0_cnt;
    bus.DATA0 = 8'hA5; bus.REQ0 = 1'b1;
    tick();
    chk("t1_gnt_next", bus.GNT, 2'b01);
    repeat (29) tick();
    chk("t1_ack0_cnt", ack0_cnt - a0, 1);
    chk("t1_byte", col, 8'hA5);

    // contention from reset
    rst = 1'b1; drop_on_ack = 0;
    bus.DATA0 = 8'h11; bus.DATA1 = 8'h22; bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    tick();
    rst = 1'b0;
    obs_q.delete();
    a0 = ack0_cnt; a1 = ack1_cnt;
    repeat (98) tick();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    repeat (10) tick();
    chk("t2_nbytes", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("t2_b0", obs_q[0], 8'h11);
      chk("t2_b1", obs_q[1], 8'h22);
      chk("t2_b2", obs_q[2], 8'h11);
      chk("t2_b3", obs_q[3], 8'h22);
    end
    chk("t2_ack0", ack0_cnt - a0, 2);
    chk("t2_ack1", ack1_cnt - a1, 2);
    drop_on_ack = 1;

    // timeout
    e0 = err_cnt; a1 = ack1_cnt;
    wait_force = 1'b1; bus.DATA1 = 8'($urandom); bus.REQ1 = 1'b1;
    repeat (50) tick();
    wait_force = 1'b0;
    repeat (5) tick();
    chk("t3_err", err_cnt - e0, 1);
    chk("t3_ack1", ack1_cnt - a1, 1);
    chk("t3_idle", bus.BUSY, 1'b0);

    // reset mid-transfer at RUN cycle 10, request kept for a fresh transfer
    a0 = ack0_cnt;
    bus.DATA0 = 8'($urandom); bus.REQ0 = 1'b1;
    for (int i = 0; i < 40 && mt != 10; i++) tick();
    chk("t4_reach_run10", mt, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", bus.BUSY, 1'b0);
    chk("t4_no_ack", ack0_cnt - a0, 0);
    repeat (30) tick();
    chk("t4_fresh_ack", ack0_cnt - a0, 1);

    // withdrawn request with DATA0 changing mid-RUN
    a0 = ack0_cnt;
    bus.DATA0 = 8'h3C; bus.REQ0 = 1'b1;
    for (int i = 0; i < 40 && mt != 5; i++) tick();
    chk("t5_reach_run5", mt, 5);
    bus.REQ0 = 1'b0; bus.DATA0 = 8'hFF;
    repeat (30) tick();
    chk("t5_byte", col, 8'h3C);
    chk("t5_ack0", ack0_cnt - a0, 1);

    // randomized requesters
    rnd = 1;
    repeat (800) tick();
    rnd = 0;
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    repeat (50) tick();
    chk("t6_idle", bus.BUSY, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
